// File: rtl/id_ex_hazard_ctrl_if.sv
// Interface between the ID-stage pipeline fields and the hazard controller.
// master = pipeline side (drives fields, consumes controls), slave = controller.
interface id_ex_hazard_ctrl_if #(parameter int CNT_W = 32);
  logic [31:0]      ir_id;
  logic             jump_id;
  logic             id_ex_memread;
  logic             id_ex_regwrite;
  logic [4:0]       id_ex_wreg;
  logic             ex_mem_memread;
  logic [4:0]       ex_mem_wreg;
  logic             branch_taken_ex;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             stall_busy;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output ir_id, jump_id, id_ex_memread, id_ex_regwrite, id_ex_wreg,
           ex_mem_memread, ex_mem_wreg, branch_taken_ex,
    input  pc_write, if_id_write, if_id_flush, id_ex_bubble, stall_busy,
           stall_count, flush_count
  );

  modport slave (
    input  ir_id, jump_id, id_ex_memread, id_ex_regwrite, id_ex_wreg,
           ex_mem_memread, ex_mem_wreg, branch_taken_ex,
    output pc_write, if_id_write, if_id_flush, id_ex_bubble, stall_busy,
           stall_count, flush_count
  );
endinterface

// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX hazard controller: load-use and jr-operand stalls, jump/branch
// flushes, a two-state stall FSM for the extra jr-after-load cycle, and
// stall/flush performance counters.
module id_ex_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input logic               clk,
  input logic               reset,
  id_ex_hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN, STALL_EXTRA} state_t;

  state_t           state;
  logic [1:0]       rem;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic [4:0] rs, rt;
  logic [5:0] opcode, funct;
  logic       is_jr;
  logic       hit_lu, hit_jr_alu, hit_jr_ex, hit_jr_mem;
  logic [1:0] need;
  logic       branch, stall, flush;
  logic       unused_bits;

  assign rs          = hz.ir_id[25:21];
  assign rt          = hz.ir_id[20:16];
  assign opcode      = hz.ir_id[31:26];
  assign funct       = hz.ir_id[5:0];
  assign unused_bits = ^hz.ir_id[15:6];

  // Hazard sources; $0 never matches, so every compare is qualified by a nonzero register.
  always_comb begin
    is_jr      = (opcode == 6'd0) && (funct == 6'h08 || funct == 6'h09);
    hit_lu     = hz.id_ex_memread && (hz.id_ex_wreg != 5'd0) &&
                 (hz.id_ex_wreg == rs || hz.id_ex_wreg == rt);
    hit_jr_alu = is_jr && hz.id_ex_regwrite && !hz.id_ex_memread &&
                 (hz.id_ex_wreg != 5'd0) && (hz.id_ex_wreg == rs);
    hit_jr_ex  = is_jr && hz.id_ex_memread &&
                 (hz.id_ex_wreg != 5'd0) && (hz.id_ex_wreg == rs);
    hit_jr_mem = is_jr && hz.ex_mem_memread &&
                 (hz.ex_mem_wreg != 5'd0) && (hz.ex_mem_wreg == rs);
    need = 2'd0;
    if (hit_lu || hit_jr_alu || hit_jr_mem) need = 2'd1;
    if (hit_jr_ex)                          need = 2'd2;
  end

  // Control decisions; branch outranks stalls, stalls outrank the ID jump flush.
  always_comb begin
    branch = !reset && hz.branch_taken_ex;
    stall  = !reset && !branch && ((state == STALL_EXTRA) || (need != 2'd0));
    flush  = branch || (!reset && hz.jump_id && !stall);
  end

  assign hz.pc_write     = !stall;
  assign hz.if_id_write  = !stall;
  assign hz.if_id_flush  = flush;
  assign hz.id_ex_bubble = branch || stall;
  assign hz.stall_busy   = (state == STALL_EXTRA);
  assign hz.stall_count  = stall_cnt;
  assign hz.flush_count  = flush_cnt;

  // Stall FSM and performance counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      rem       <= 2'd0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + CNT_W'(stall);
      flush_cnt <= flush_cnt + CNT_W'(flush);
      if (branch) begin
        state <= RUN;
        rem   <= 2'd0;
      end else if (state == RUN) begin
        if (need == 2'd2) begin
          state <= STALL_EXTRA;
          rem   <= 2'd1;
        end
      end else begin
        rem <= rem - 2'd1;
        if (rem <= 2'd1) state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Scoreboard bench for id_ex_hazard_ctrl: a driver applies directed and
// random cycles and queues the reference model's expected outputs; a monitor
// on the falling edge pops and compares.
module tb_id_ex_hazard_ctrl;
  localparam int CNT_W = 32;

  typedef struct packed {
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             stall_busy;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
  } exp_t;

  typedef struct {
    exp_t  e;
    string tag;
  } item_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  id_ex_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();
  id_ex_hazard_ctrl #(.CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .hz(hz.slave));

  item_t q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  // reference model state: pending extra stall cycles and counters
  int          extra_left = 0;
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  localparam logic [31:0] ADD_9_8_10 = 32'h010A4820;
  localparam logic [31:0] JR31       = 32'h03E00008;
  localparam logic [31:0] ADD_0_0_0  = 32'h00000020;

  function automatic int model_need(logic [31:0] ir, logic mr, logic rw, logic [4:0] wr,
                                    logic emr, logic [4:0] ewr);
    int rs = int'(ir[25:21]);
    int rt = int'(ir[20:16]);
    bit jr = (ir[31:26] == 6'd0) && (ir[5:0] == 6'h08 || ir[5:0] == 6'h09);
    int n = 0;
    int w = int'(wr);
    int ew = int'(ewr);
    if (mr && w != 0 && (w == rs || w == rt)) n = (n > 1) ? n : 1;
    if (jr && rw && !mr && w != 0 && w == rs) n = (n > 1) ? n : 1;
    if (jr && mr && w != 0 && w == rs)        n = 2;
    if (jr && emr && ew != 0 && ew == rs)     n = (n > 1) ? n : 1;
    return n;
  endfunction

  // One cycle: apply inputs just after the rising edge, queue what the model expects.
  task automatic drive(input string tag, input logic rst, input logic [31:0] ir,
                       input logic jmp, input logic mr, input logic rw, input logic [4:0] wr,
                       input logic emr, input logic [4:0] ewr, input logic br);
    item_t it;
    bit stall, flush, bubble;
    @(posedge clk);
    #1;
    reset = rst;
    hz.ir_id = ir; hz.jump_id = jmp; hz.id_ex_memread = mr; hz.id_ex_regwrite = rw;
    hz.id_ex_wreg = wr; hz.ex_mem_memread = emr; hz.ex_mem_wreg = ewr; hz.branch_taken_ex = br;
    if (rst) begin
      extra_left = 0; m_stall = 0; m_flush = 0;
      stall = 0; flush = 0; bubble = 0;
      it.e.stall_busy = 1'b0;
    end else begin
      it.e.stall_busy = (extra_left > 0);
      if (br) begin
        stall = 0; flush = 1; bubble = 1;
        extra_left = 0;
      end else if (extra_left > 0) begin
        stall = 1; flush = 0; bubble = 1;
        extra_left = extra_left - 1;
      end else begin
        int n = model_need(ir, mr, rw, wr, emr, ewr);
        stall = (n > 0);
        flush = jmp && !stall;
        bubble = stall;
        if (n == 2) extra_left = 1;
      end
    end
    it.e.pc_write     = !stall;
    it.e.if_id_write  = !stall;
    it.e.if_id_flush  = flush;
    it.e.id_ex_bubble = bubble;
    it.e.stall_count  = m_stall;
    it.e.flush_count  = m_flush;
    it.tag = tag;
    q.push_back(it);
    if (!rst) begin
      m_stall = m_stall + (stall ? 1 : 0);
      m_flush = m_flush + (flush ? 1 : 0);
    end
  endtask

  task automatic idle(input string tag);
    drive(tag, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
  endtask

  // Monitor: compare every queued expectation on the falling edge.
  initial begin
    item_t it;
    exp_t  act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        it = q.pop_front();
        act = '{hz.pc_write, hz.if_id_write, hz.if_id_flush, hz.id_ex_bubble,
                hz.stall_busy, hz.stall_count, hz.flush_count};
        n_cmp++;
        if (act !== it.e) begin
          n_bad++;
          $display("FAIL %s: got pcw=%b ifw=%b fl=%b bub=%b busy=%b sc=%0d fc=%0d, want pcw=%b ifw=%b fl=%b bub=%b busy=%b sc=%0d fc=%0d",
                   it.tag, act.pc_write, act.if_id_write, act.if_id_flush, act.id_ex_bubble,
                   act.stall_busy, act.stall_count, act.flush_count,
                   it.e.pc_write, it.e.if_id_write, it.e.if_id_flush, it.e.id_ex_bubble,
                   it.e.stall_busy, it.e.stall_count, it.e.flush_count);
        end
      end
    end
  end

  initial begin
    hz.ir_id = '0; hz.jump_id = 0; hz.id_ex_memread = 0; hz.id_ex_regwrite = 0;
    hz.id_ex_wreg = '0; hz.ex_mem_memread = 0; hz.ex_mem_wreg = '0; hz.branch_taken_ex = 0;
    // reset state, with a hazard present on the inputs to prove the gating
    drive("reset", 1'b1, ADD_9_8_10, 1'b0, 1'b1, 1'b0, 5'd8, 1'b0, 5'd0, 1'b0);
    idle("after_reset");

    // load-use: one stall, then bubble in ID/EX lets things move
    drive("lu_stall", 1'b0, ADD_9_8_10, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0, 1'b0);
    drive("lu_resume", 1'b0, ADD_9_8_10, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8, 1'b0);
    idle("lu_count");

    // jr after lw: two stalls, then the jump flush
    drive("jrlw_c1", 1'b0, JR31, 1'b1, 1'b1, 1'b1, 5'd31, 1'b0, 5'd0, 1'b0);
    drive("jrlw_c2", 1'b0, JR31, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd31, 1'b0);
    drive("jrlw_c3", 1'b0, JR31, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    idle("jrlw_count");

    // jr after ALU: exactly one stall, no extra state
    drive("jralu_c1", 1'b0, JR31, 1'b1, 1'b0, 1'b1, 5'd31, 1'b0, 5'd0, 1'b0);
    drive("jralu_c2", 1'b0, JR31, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    idle("jralu_count");

    // branch taken while in the extra stall cycle
    drive("brx_c1", 1'b0, JR31, 1'b1, 1'b1, 1'b1, 5'd31, 1'b0, 5'd0, 1'b0);
    drive("brx_c2", 1'b0, JR31, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd31, 1'b1);
    idle("brx_run");

    // $0 never hazards
    drive("reg0", 1'b0, ADD_0_0_0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0);

    // reset asserted mid-stall
    drive("rst_c1", 1'b0, JR31, 1'b1, 1'b1, 1'b1, 5'd31, 1'b0, 5'd0, 1'b0);
    drive("rst_mid", 1'b1, JR31, 1'b1, 1'b1, 1'b1, 5'd31, 1'b0, 5'd0, 1'b0);
    idle("rst_after");

    // random traffic over a small register range so hazards are frequent
    for (int i = 0; i < 600; i++) begin
      logic [31:0] ir;
      logic [5:0]  fn;
      case ($urandom_range(0, 2))
        0:       fn = 6'h08;
        1:       fn = 6'h09;
        default: fn = 6'h20;
      endcase
      ir = {($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0,
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 10'($urandom), fn};
      drive("rand", ($urandom_range(0, 60) == 0), ir, 1'($urandom),
            1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
            1'($urandom), 5'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
    end
    idle("tail");

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/id_ex_hazard_ctrl.md
Name: id_ex_hazard_ctrl

Overview:
- Hazard and pipeline-control block that decides, each cycle, what the ID/EX pipeline register captures: the normal decode, or a bubble (all control signals zero).
- It also decides whether PC and IF/ID advance, hold or flush.
- It sits beside the ID stage. It reads the instruction in ID, the destination and control fields already latched in ID/EX and EX/MEM, and the EX-stage branch resolution.
- It carries a small stall FSM and performance counters.

Parameters:
CNT_W, 32, width of the stall and flush performance counters.

Ports:
clk  input  1  clock, rising edge
reset  input  1  reset, asynchronous, active-high
ir_id  input  32  instruction in ID; rs=[25:21], rt=[20:16], opcode=[31:26], funct=[5:0]
jump_id  input  1  ID decoded j/jal/jr/jalr (PC redirected from ID)
id_ex_memread  input  1  MemRead held in ID/EX
id_ex_regwrite  input  1  RegWrite held in ID/EX
id_ex_wreg  input  5  destination register resolved for the ID/EX instruction
ex_mem_memread  input  1  MemRead held in EX/MEM
ex_mem_wreg  input  5  destination register of the EX/MEM instruction
branch_taken_ex  input  1  branch in EX resolved taken this cycle
pc_write  output  1  PC register load enable
if_id_write  output  1  IF/ID load enable
if_id_flush  output  1  IF/ID loads zero (nop)
id_ex_bubble  output  1  ID/EX control fields load zero
stall_busy  output  1  FSM in STALL_EXTRA
stall_count  output  CNT_W  cycles with a stall asserted, wraps
flush_count  output  CNT_W  cycles with if_id_flush asserted, wraps

Behaviour:
- Register state: FSM {RUN, STALL_EXTRA}, rem[1:0], stall_count, flush_count.
- Reset (async): FSM=RUN, rem=0, both counters=0.
- While reset is high, the combinational outputs take idle values: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_bubble=0, stall_busy=0.
- Register 0 never causes a hazard; every compare requires the matched register != 0.
- is_jr = (opcode==0) && (funct==6'h08 || funct==6'h09).
- Hazard detection is evaluated only in RUN. need (0..2) is the max of:
  - load-use: id_ex_memread && id_ex_wreg in {rs, rt} -> 1.
  - jr after ALU: is_jr && id_ex_regwrite && !id_ex_memread && id_ex_wreg==rs -> 1.
  - jr after load in EX: is_jr && id_ex_memread && id_ex_wreg==rs -> 2.
  - jr after load in MEM: is_jr && ex_mem_memread && ex_mem_wreg==rs -> 1.
- Stall cycle outputs: pc_write=0, if_id_write=0, id_ex_bubble=1, if_id_flush=0.
- RUN, no branch, need>=1: stall this cycle (combinational, same cycle as detection).
  - If need==2: next FSM=STALL_EXTRA, rem=1.
- STALL_EXTRA, no branch: stall this cycle with no re-evaluation; rem decrements; FSM returns to RUN when rem reaches 0.
  - With need==2, the total is exactly 2 consecutive stall cycles.
- Jump in ID: jump_id=1 in a cycle with no stall -> if_id_flush=1, pc_write=1, if_id_write=1, id_ex_bubble=0.
  - If a stall is active, the flush is suppressed and the jump is retried once the stall ends.
- Branch taken in EX (highest priority, any state): pc_write=1, if_id_write=1, if_id_flush=1, id_ex_bubble=1.
  - Pending stall is cancelled: next FSM=RUN, rem=0. No stall is counted that cycle.
- Counters: stall_count +1 on every stall cycle; flush_count +1 on every cycle with if_id_flush=1. Both wrap modulo 2^CNT_W.
- stall_busy = (FSM==STALL_EXTRA).

Test Plan:
- Load-use: id_ex_memread=1, id_ex_wreg=8, ir_id=add $9,$8,$10 -> one cycle of pc_write=0, id_ex_bubble=1; then (bubble in ID/EX) pc_write=1; stall_count=1.
- jr after lw: id_ex_memread=1, id_ex_regwrite=1, id_ex_wreg=31, ir_id=jr $31 (32'h03E00008), jump_id=1 -> two consecutive stall cycles, stall_busy=1 in cycle 2, then if_id_flush=1 in cycle 3; stall_count=2, flush_count=1.
- jr after ALU: id_ex_regwrite=1, id_ex_memread=0, id_ex_wreg=31, ir_id=jr $31 -> exactly one stall cycle, no STALL_EXTRA.
- Branch during STALL_EXTRA: trigger the lw/jr case, assert branch_taken_ex in cycle 2 -> that cycle if_id_flush=1, id_ex_bubble=1, pc_write=1; FSM=RUN next; stall_count=1, flush_count=1.
- Register 0: id_ex_memread=1, id_ex_wreg=0, ir_id uses $0 -> no stall, all outputs idle.
- Reset mid-stall: assert reset while in STALL_EXTRA -> immediately FSM=RUN, counters=0, pc_write=1, id_ex_bubble=0.
